// File: rtl/uart_host_if_if.sv
// Host-side byte bus for uart_host_if: a TX write channel and an RX show-ahead read channel.
// Both channels: a beat transfers on the rising clk edge where valid && ready; valid never waits on ready.
interface uart_host_if_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/uart_host_if.sv
// Host partner of the UART core: TX FIFO feeding a start/busy launch FSM, and an
// edge-captured RX FIFO with sticky overrun. Host outputs come only from registers.
module uart_host_if #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_host_if_if.slave               host,
  output logic                        overrun_o,
  input  logic                        clr_overrun_i,
  output logic [$clog2(TX_DEPTH):0]   tx_level_o,
  output logic [$clog2(RX_DEPTH):0]   rx_level_o,
  output logic                        uart_tx_start_o,
  output logic [7:0]                  uart_tx_data_o,
  input  logic                        uart_tx_busy_i,
  input  logic [7:0]                  uart_rx_data_i,
  input  logic                        uart_data_ready_i,
  output logic [1:0]                  state_o
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW-1:0] TX_P1   = TAW'(1);
  localparam logic [TAW:0]   TX_L1   = (TAW+1)'(1);
  localparam logic [TAW:0]   TX_FULL = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW-1:0] RX_P1   = RAW'(1);
  localparam logic [RAW:0]   RX_L1   = (RAW+1)'(1);
  localparam logic [RAW:0]   RX_FULL = (RAW+1)'(RX_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } tx_state_e;

  // ---------------- TX FIFO ----------------
  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [TAW-1:0] tx_wptr_q, tx_rptr_q;
  logic [TAW:0]   tx_level_q, tx_level_d;
  logic           tx_push, tx_pop;

  assign host.wr_ready = (tx_level_q != TX_FULL);
  assign tx_push       = host.wr_valid && host.wr_ready;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= host.wr_data;
  end

  always_comb begin
    tx_level_d = tx_level_q;
    if (tx_push && !tx_pop)      tx_level_d = tx_level_q + TX_L1;
    else if (!tx_push && tx_pop) tx_level_d = tx_level_q - TX_L1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_level_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + TX_P1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + TX_P1;
      tx_level_q <= tx_level_d;
    end
  end

  // ---------------- TX launch FSM ----------------
  tx_state_e  state_q, state_d;
  logic       start_q, start_d;
  logic [7:0] tx_data_q, tx_data_d;

  // START holds the request until the transmitter shows busy, since it may only
  // accept on its own baud tick.
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    tx_data_d = tx_data_q;
    tx_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_level_q != '0 && !uart_tx_busy_i) begin
          tx_pop    = 1'b1;
          tx_data_d = tx_mem_q[tx_rptr_q];
          start_d   = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (uart_tx_busy_i) begin
          start_d = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!uart_tx_busy_i) state_d = S_IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign uart_tx_start_o = start_q;
  assign uart_tx_data_o  = tx_data_q;
  assign state_o         = state_q;
  assign tx_level_o      = tx_level_q;

  // ---------------- RX FIFO ----------------
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [RAW-1:0] rx_wptr_q, rx_rptr_q, rx_rptr_d;
  logic [RAW:0]   rx_level_q, rx_level_d;
  logic [7:0]     rd_data_q, rd_data_d;
  logic           dr_q, ovr_q, ovr_d;
  logic           rx_edge, rx_pop, rx_full, rx_push, ovr_set;

  assign rx_edge = uart_data_ready_i && !dr_q;
  assign rx_pop  = (rx_level_q != '0) && host.rd_ready;
  assign rx_full = (rx_level_q == RX_FULL);
  assign rx_push = rx_edge && (!rx_full || rx_pop);
  assign ovr_set = rx_edge && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= uart_rx_data_i;
  end

  // rd_data is registered: the next head is looked up ahead, bypassing the byte being
  // written when it becomes the only entry.
  always_comb begin
    rx_rptr_d  = rx_pop ? rx_rptr_q + RX_P1 : rx_rptr_q;
    rx_level_d = rx_level_q;
    if (rx_push && !rx_pop)      rx_level_d = rx_level_q + RX_L1;
    else if (!rx_push && rx_pop) rx_level_d = rx_level_q - RX_L1;
    rd_data_d = rd_data_q;
    if (rx_level_d != '0) begin
      if (rx_push && (rx_wptr_q == rx_rptr_d)) rd_data_d = uart_rx_data_i;
      else                                     rd_data_d = rx_mem_q[rx_rptr_d];
    end
    ovr_d = ovr_q;
    if (ovr_set)            ovr_d = 1'b1;
    else if (clr_overrun_i) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_level_q <= '0;
      rd_data_q  <= '0;
      dr_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + RX_P1;
      rx_rptr_q  <= rx_rptr_d;
      rx_level_q <= rx_level_d;
      rd_data_q  <= rd_data_d;
      dr_q       <= uart_data_ready_i;
      ovr_q      <= ovr_d;
    end
  end

  assign host.rd_valid = (rx_level_q != '0);
  assign host.rd_data  = rd_data_q;
  assign rx_level_o    = rx_level_q;
  assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_uart_host_if.sv
// Self-checking bench for uart_host_if: transmitter busy model, RX queue model, directed
// scenarios and randomized traffic.
module tb_uart_host_if;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       overrun, clr_overrun, uart_tx_start, uart_tx_busy, uart_data_ready;
  logic [4:0] tx_level, rx_level;
  logic [7:0] uart_tx_data, uart_rx_data;
  logic [1:0] state;

  always #5 clk = ~clk;

  uart_host_if_if bus ();

  uart_host_if #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .host              (bus),
    .overrun_o         (overrun),
    .clr_overrun_i     (clr_overrun),
    .tx_level_o        (tx_level),
    .rx_level_o        (rx_level),
    .uart_tx_start_o   (uart_tx_start),
    .uart_tx_data_o    (uart_tx_data),
    .uart_tx_busy_i    (uart_tx_busy),
    .uart_rx_data_i    (uart_rx_data),
    .uart_data_ready_i (uart_data_ready),
    .state_o           (state)
  );

  int checks = 0;
  int errors = 0;

  // TX scoreboard: bytes the transmitter must receive, in order
  logic [7:0] exp_q[$];
  int         n_acc = 0;
  bit         model_en = 1'b0;
  logic       busy_hold = 1'b0;
  logic       busy_m = 1'b0;

  // RX reference: queue of held bytes, sticky overrun, last data_ready level
  logic [7:0] rx_q[$];
  logic       ovr_m = 1'b0;
  logic       prev_dr_m = 1'b0;

  assign uart_tx_busy = model_en ? busy_m : busy_hold;

  // Transmitter model: accepts a start after a random baud delay, stays busy a random time.
  initial begin : tx_model
    int phase, dly, bcnt;
    logic [7:0] hold, e;
    phase = 0; dly = 0; bcnt = 0; hold = '0;
    forever begin
      @(negedge clk);
      if (rst || !model_en) begin
        phase  = 0;
        busy_m = 1'b0;
      end else begin
        case (phase)
          0: if (uart_tx_start === 1'b1) begin
               hold  = uart_tx_data;
               dly   = $urandom_range(0, 3);
               phase = 1;
             end
          1: begin
               checks++;
               if (uart_tx_start !== 1'b1 || uart_tx_data !== hold) begin
                 errors++;
                 $display("FAIL tx_hold start=%b data=%02h exp start=1 data=%02h",
                          uart_tx_start, uart_tx_data, hold);
               end
               if (dly == 0) begin
                 busy_m = 1'b1;
                 n_acc++;
                 checks++;
                 if (exp_q.size() == 0) begin
                   errors++;
                   $display("FAIL tx_extra got=%02h exp=none", hold);
                 end else begin
                   e = exp_q.pop_front();
                   if (hold !== e) begin
                     errors++;
                     $display("FAIL tx_order got=%02h exp=%02h", hold, e);
                   end
                 end
                 bcnt  = $urandom_range(3, 8);
                 phase = 2;
               end else dly--;
             end
          2: begin
               checks++;
               if (uart_tx_start !== 1'b0) begin
                 errors++;
                 $display("FAIL tx_start_drop got=%b exp=0", uart_tx_start);
               end
               bcnt--;
               if (bcnt == 0) begin
                 busy_m = 1'b0;
                 phase  = 3;
               end
             end
          default: begin
               checks++;
               if (uart_tx_start !== 1'b0) begin
                 errors++;
                 $display("FAIL tx_gap got=%b exp=0", uart_tx_start);
               end
               phase = 0;
             end
        endcase
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic host_write(input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic rx_drive(input logic dr, input logic [7:0] d, input logic pop, input logic clr);
    logic edge_s, full_s;
    uart_data_ready = dr;
    uart_rx_data    = d;
    bus.rd_ready    = pop;
    clr_overrun     = clr;
    if (pop && rx_q.size() > 0) void'(rx_q.pop_front());
    edge_s = dr && !prev_dr_m;
    full_s = (rx_q.size() >= DEPTH);
    if (edge_s && !full_s) rx_q.push_back(d);
    if (edge_s && full_s) ovr_m = 1'b1;
    else if (clr)         ovr_m = 1'b0;
    prev_dr_m = dr;
    tick();
    bus.rd_ready = 1'b0;
    clr_overrun  = 1'b0;
  endtask

  task automatic wait_tx_drain(input string tag);
    int i;
    i = 0;
    while (i < 3000 && !(exp_q.size() == 0 && tx_level == 0 && state == 2'd0 && uart_tx_busy == 1'b0)) begin
      tick();
      i++;
    end
    checks++;
    if (i >= 3000) begin
      errors++;
      $display("FAIL %s_drain got=timeout pending=%0d level=%0d exp=drained", tag, exp_q.size(), tx_level);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    exp_q.delete();
    rx_q.delete();
    ovr_m = 1'b0;
    prev_dr_m = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.wr_ready !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_host got=wr_ready %b rd_valid %b rd_data %02h ovr %b exp=1 0 00 0",
               bus.wr_ready, bus.rd_valid, bus.rd_data, overrun);
    end
    checks++;
    if (uart_tx_start !== 1'b0 || uart_tx_data !== 8'h00 || tx_level !== 5'd0 || rx_level !== 5'd0 || state !== 2'd0) begin
      errors++;
      $display("FAIL reset_uart got=start %b data %02h txl %0d rxl %0d st %0d exp=0 00 0 0 0",
               uart_tx_start, uart_tx_data, tx_level, rx_level, state);
    end
  endtask

  task automatic test_single_tx();
    int n0, k, extra;
    n0 = n_acc;
    model_en = 1'b1;
    exp_q.push_back(8'h55);
    host_write(8'h55);
    checks++;
    if (tx_level !== 5'd1) begin
      errors++;
      $display("FAIL single_level1 got=%0d exp=1", tx_level);
    end
    k = 0;
    while (k < 2 && uart_tx_start !== 1'b1) begin
      tick();
      k++;
    end
    checks++;
    if (uart_tx_start !== 1'b1 || uart_tx_data !== 8'h55 || tx_level !== 5'd0) begin
      errors++;
      $display("FAIL single_start got=start %b data %02h level %0d exp=1 55 0", uart_tx_start, uart_tx_data, tx_level);
    end
    wait_tx_drain("single");
    extra = 0;
    repeat (10) begin
      tick();
      if (uart_tx_start !== 1'b0) extra++;
    end
    checks++;
    if (n_acc - n0 != 1 || extra != 0) begin
      errors++;
      $display("FAIL single_frames got=%0d late_starts=%0d exp=1 0", n_acc - n0, extra);
    end
  endtask

  task automatic test_burst();
    int n0;
    n0 = n_acc;
    model_en  = 1'b0;
    busy_hold = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(i);
      exp_q.push_back(8'(i));
      tick();
    end
    checks++;
    if (bus.wr_ready !== 1'b0 || tx_level !== 5'd16 || state !== 2'd0) begin
      errors++;
      $display("FAIL burst_full got=wr_ready %b level %0d st %0d exp=0 16 0", bus.wr_ready, tx_level, state);
    end
    bus.wr_data = 8'h11;
    tick();
    bus.wr_valid = 1'b0;
    checks++;
    if (tx_level !== 5'd16) begin
      errors++;
      $display("FAIL burst_refuse got=%0d exp=16", tx_level);
    end
    busy_hold = 1'b0;
    model_en  = 1'b1;
    wait_tx_drain("burst");
    checks++;
    if (n_acc - n0 != DEPTH) begin
      errors++;
      $display("FAIL burst_count got=%0d exp=%0d", n_acc - n0, DEPTH);
    end
  endtask

  task automatic test_rx_edge();
    rx_drive(1'b1, 8'hA5, 1'b0, 1'b0);
    rx_drive(1'b0, 8'($urandom), 1'b0, 1'b0);
    rx_drive(1'b1, 8'h3C, 1'b0, 1'b0);
    repeat (4) rx_drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    rx_drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (rx_level !== 5'd2 || bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL rx_edge_two got=level %0d valid %b data %02h exp=2 1 a5", rx_level, bus.rd_valid, bus.rd_data);
    end
    rx_drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (rx_level !== 5'd1 || bus.rd_data !== 8'h3C) begin
      errors++;
      $display("FAIL rx_edge_pop got=level %0d data %02h exp=1 3c", rx_level, bus.rd_data);
    end
    rx_drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (rx_level !== 5'd0 || bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_edge_empty got=level %0d valid %b exp=0 0", rx_level, bus.rd_valid);
    end
  endtask

  task automatic test_rx_overrun();
    for (int i = 0; i < DEPTH; i++) begin
      rx_drive(1'b1, 8'($urandom), 1'b0, 1'b0);
      rx_drive(1'b0, 8'h00, 1'b0, 1'b0);
    end
    rx_drive(1'b1, 8'hEE, 1'b0, 1'b0);
    rx_drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b1 || rx_level !== 5'd16 || bus.rd_data !== rx_q[0]) begin
      errors++;
      $display("FAIL ovr_set got=ovr %b level %0d head %02h exp=1 16 %02h", overrun, rx_level, bus.rd_data, rx_q[0]);
    end
    rx_drive(1'b1, 8'hDD, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set_wins got=%b exp=1", overrun);
    end
    rx_drive(1'b0, 8'h00, 1'b0, 1'b0);
    rx_drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear got=%b exp=0", overrun);
    end
    rx_drive(1'b1, 8'h77, 1'b1, 1'b0);
    rx_drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b0 || rx_level !== 5'd16) begin
      errors++;
      $display("FAIL ovr_pop_accept got=ovr %b level %0d exp=0 16", overrun, rx_level);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (bus.rd_data !== rx_q[0]) begin
        errors++;
        $display("FAIL ovr_contents[%0d] got=%02h exp=%02h", i, bus.rd_data, rx_q[0]);
      end
      rx_drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++;
    if (rx_level !== 5'd0) begin
      errors++;
      $display("FAIL ovr_drained got=%0d exp=0", rx_level);
    end
  endtask

  task automatic test_simultaneous();
    int n0;
    n0 = n_acc;
    model_en  = 1'b0;
    busy_hold = 1'b1;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC3);
    host_write(8'hA1);
    host_write(8'hB2);
    busy_hold = 1'b0;
    host_write(8'hC3);
    checks++;
    if (tx_level !== 5'd2 || uart_tx_start !== 1'b1 || uart_tx_data !== 8'hA1) begin
      errors++;
      $display("FAIL simul_tx got=level %0d start %b data %02h exp=2 1 a1", tx_level, uart_tx_start, uart_tx_data);
    end
    model_en = 1'b1;
    wait_tx_drain("simul");
    checks++;
    if (n_acc - n0 != 3) begin
      errors++;
      $display("FAIL simul_tx_count got=%0d exp=3", n_acc - n0);
    end
    rx_drive(1'b1, 8'h12, 1'b0, 1'b0);
    rx_drive(1'b0, 8'h00, 1'b0, 1'b0);
    rx_drive(1'b1, 8'h34, 1'b0, 1'b0);
    rx_drive(1'b0, 8'h00, 1'b0, 1'b0);
    rx_drive(1'b1, 8'h56, 1'b1, 1'b0);
    rx_drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (rx_level !== 5'd2 || bus.rd_data !== 8'h34) begin
      errors++;
      $display("FAIL simul_rx got=level %0d head %02h exp=2 34", rx_level, bus.rd_data);
    end
    rx_drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.rd_data !== 8'h56 || rx_level !== 5'd1) begin
      errors++;
      $display("FAIL simul_rx_order got=head %02h level %0d exp=56 1", bus.rd_data, rx_level);
    end
    rx_drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    model_en  = 1'b0;
    busy_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'($urandom);
      tick();
    end
    bus.wr_valid = 1'b0;
    tick();
    checks++;
    if (state !== 2'd1 || tx_level !== 5'd3 || uart_tx_start !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup got=st %0d level %0d start %b exp=1 3 1", state, tx_level, uart_tx_start);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (uart_tx_start !== 1'b0 || uart_tx_data !== 8'h00 || tx_level !== 5'd0 || state !== 2'd0 ||
        bus.wr_ready !== 1'b1 || bus.rd_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL areset_async got=start %b data %02h level %0d st %0d wr_ready %b exp=0 00 0 0 1",
               uart_tx_start, uart_tx_data, tx_level, state, bus.wr_ready);
    end
    tick();
    apply_reset();
    model_en = 1'b1;
  endtask

  task automatic test_random_rx();
    logic dr, pop, clr;
    for (int i = 0; i < 300; i++) begin
      dr  = 1'($urandom_range(0, 1));
      pop = (i < 150) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 7) == 0);
      rx_drive(dr, 8'($urandom), pop, clr);
      checks++;
      if (rx_level !== 5'(rx_q.size()) || overrun !== ovr_m || bus.rd_valid !== (rx_q.size() > 0) ||
          (rx_q.size() > 0 && bus.rd_data !== rx_q[0])) begin
        errors++;
        $display("FAIL rand_rx[%0d] got=level %0d ovr %b data %02h exp=%0d %b %02h", i, rx_level, overrun,
                 bus.rd_data, rx_q.size(), ovr_m, (rx_q.size() > 0) ? rx_q[0] : 8'h00);
      end
    end
    rx_drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_random_tx();
    int n0, nexp;
    logic [7:0] d;
    n0   = n_acc;
    nexp = 0;
    model_en = 1'b1;
    for (int i = 0; i < 120; i++) begin
      d = 8'($urandom);
      bus.wr_valid = ($urandom_range(0, 2) == 0);
      bus.wr_data  = d;
      checks++;
      if (bus.wr_ready !== (tx_level != 5'd16)) begin
        errors++;
        $display("FAIL rand_wr_ready got=%b level %0d", bus.wr_ready, tx_level);
      end
      if (bus.wr_valid && bus.wr_ready) begin
        exp_q.push_back(d);
        nexp++;
      end
      tick();
    end
    bus.wr_valid = 1'b0;
    wait_tx_drain("rand_tx");
    checks++;
    if (n_acc - n0 != nexp) begin
      errors++;
      $display("FAIL rand_tx_count got=%0d exp=%0d", n_acc - n0, nexp);
    end
  endtask

  initial begin : main
    bus.wr_valid    = 1'b0;
    bus.wr_data     = 8'h00;
    bus.rd_ready    = 1'b0;
    clr_overrun     = 1'b0;
    uart_data_ready = 1'b0;
    uart_rx_data    = 8'h00;
    test_reset();
    test_single_tx();
    test_burst();
    test_rx_edge();
    test_rx_overrun();
    test_simultaneous();
    test_async_reset();
    test_random_rx();
    test_random_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
